// File: rtl/lcd_int_seq.sv
// lcd_int_seq: sequential binary-to-decimal 7-segment driver.
// Converts a W-bit unsigned value to DIGITS BCD digits with double-dabble,
// one input bit per clock. Then it decodes each digit to active-high segments
// (bit6=a .. bit0=g).
// Optional feature: define LCD_INT_BLANK_EN to blank leading zero digits.
module lcd_int_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);
    // Handshake: start is only looked at in IDLE or DONE. When it is taken,
    // bin_in is captured on that edge. busy is high for the W shift cycles.
    // done pulses for one cycle when bcd_out/seg_out/overflow change. These
    // outputs hold until the next done pulse. start is ignored while busy.

    // Internal digit count, enough to hold any W-bit value in full.
    localparam int NI = (W + 2) / 3;
    localparam int AW = 4 * NI;
    localparam int MD = (NI > DIGITS) ? NI : DIGITS;
    // The bit counter runs 0..W-1.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          sreg_q, sreg_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         acc_adj;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [4*MD-1:0]       acc_ext;
    logic                  ovf_d;
    logic [4*DIGITS-1:0]   bcd_d;
    logic [7*DIGITS-1:0]   seg_d;
`ifdef LCD_INT_BLANK_EN
    logic                  lead_zero;
`endif

    logic                  done_q;
    logic                  ovf_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [7*DIGITS-1:0]   seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Register the state, the shift register, the accumulator and the bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on start, then do one add-3/shift step per CONV cycle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        acc_adj = acc_q;
        for (int i = 0; i < NI; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d  = bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d  = (acc_adj << 1) | AW'(sreg_q[W-1]);
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    sreg_d  = bin_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // From the finished accumulator, derive overflow, the visible BCD digits and the segment codes.
    always_comb begin
        acc_ext         = '0;
        acc_ext[AW-1:0] = acc_q;
        ovf_d           = 1'b0;
        for (int i = DIGITS; i < MD; i++) begin
            if (acc_ext[4*i +: 4] != 4'd0) begin
                ovf_d = 1'b1;
            end
        end
        bcd_d = '0;
        seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_d[4*i +: 4] = acc_ext[4*i +: 4];
            seg_d[7*i +: 7] = ovf_d ? 7'h01 : seg7(acc_ext[4*i +: 4]);
        end
`ifdef LCD_INT_BLANK_EN
        // Walk down from the top digit. Blank each digit while it and every
        // digit above it are zero. Digit 0 is always shown.
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero & (acc_ext[4*i +: 4] == 4'd0);
            if (lead_zero && !ovf_d) begin
                seg_d[7*i +: 7] = 7'h00;
            end
        end
`endif
    end

    // Output registers: capture the result while leaving DONE, and pulse done for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            bcd_q  <= '0;
            seg_q  <= {DIGITS{7'h7E}};
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                ovf_q <= ovf_d;
                bcd_q <= bcd_d;
                seg_q <= seg_d;
            end
        end
    end

    assign busy     = (state_q == S_CONV);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_lcd_int_seq.sv
// tb_lcd_int_seq: self-checking bench for lcd_int_seq (W=8, DIGITS=2), plus a
// second instance (W=10, DIGITS=4) for the wide case. The design's optional
// feature is LCD_INT_BLANK_EN. The bench follows that macro when it builds its
// expectations.
module tb_lcd_int_seq;
    localparam int W      = 8;
    localparam int DIGITS = 2;
    localparam int POW    = 100;
    localparam int W2     = 10;
    localparam int D2     = 4;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk    = 1'b0;
    logic                 reset  = 1'b1;
    logic                 start  = 1'b0;
    logic [W-1:0]         bin_in = '0;
    logic                 busy, done, overflow;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [7*DIGITS-1:0]  seg_out;

    logic                 start2 = 1'b0;
    logic [W2-1:0]        bin2   = '0;
    logic                 busy2, done2, ovf2;
    logic [4*D2-1:0]      bcd2;
    logic [7*D2-1:0]      seg2;

    always #5 clk = ~clk;

    lcd_int_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .overflow(overflow),
        .bcd_out(bcd_out), .seg_out(seg_out)
    );

    lcd_int_seq #(.W(W2), .DIGITS(D2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .overflow(ovf2),
        .bcd_out(bcd2), .seg_out(seg2)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: timed out waiting for done (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
            4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
            8: return 7'h7F;  9: return 7'h7B;  default: return 7'h00;
        endcase
    endfunction

    function automatic logic [4*DIGITS-1:0] m_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] b;
        int unsigned p;
        b = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    function automatic logic [7*DIGITS-1:0] m_seg(input int unsigned v);
        logic [7*DIGITS-1:0] s;
        int unsigned p;
        s = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v >= POW) begin
                s[7*i +: 7] = 7'h01;
            end else begin
                s[7*i +: 7] = seg_code(int'((v / p) % 10));
`ifdef LCD_INT_BLANK_EN
                if (i > 0 && v < p) s[7*i +: 7] = 7'h00;
`endif
            end
            p = p * 10;
        end
        return s;
    endfunction

    // Scoreboard timeline. A start accepted at edge k is busy after edges
    // k..k+W-1. Its result and done appear after edge k+W+1. A new start is
    // accepted once no conversion is pending.
    logic [W-1:0] exp_q[$];
    int           cyc       = 0;
    int           pend_k    = 0;
    int           done_at   = -1;
    bit           model_on  = 1'b0;
    bit           res_valid = 1'b0;
    bit           exp_busy  = 1'b0;
    int unsigned  cur_val   = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            res_valid = 1'b0;
            done_at   = -1;
            model_on  = 1'b1;
        end else begin
            if (exp_q.size() > 0 && cyc == pend_k + W + 1) begin
                cur_val   = exp_q.pop_front();
                res_valid = 1'b1;
                done_at   = cyc;
            end
            if (start && exp_q.size() == 0) begin
                exp_q.push_back(bin_in);
                pend_k = cyc;
            end
        end
        exp_busy = (exp_q.size() > 0) && (cyc <= pend_k + W - 1);
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done", 64'(done), 64'(done_at == cyc));
            chk("overflow", 64'(overflow), 64'(res_valid && cur_val >= POW));
            chk("bcd_out", 64'(bcd_out), 64'(res_valid ? m_bcd(cur_val) : '0));
            chk("seg_out", 64'(seg_out), 64'(res_valid ? m_seg(cur_val) : {DIGITS{7'h7E}}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_conv(input logic [W-1:0] v, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        for (int i = 1; i <= 3 * W && lat < 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) lat = i;
        end
        if (lat < 0) fail_timeout("run_conv");
    endtask

    task automatic directed(input string name, input logic [W-1:0] v,
                            input logic [4*DIGITS-1:0] e_bcd,
                            input logic [7*DIGITS-1:0] e_seg, input logic e_ovf);
        int lat, nb;
        run_conv(v, lat, nb);
        if (lat >= 0) begin
            chk({name, " bcd"}, 64'(bcd_out), 64'(e_bcd));
            chk({name, " seg"}, 64'(seg_out), 64'(e_seg));
            chk({name, " ovf"}, 64'(overflow), 64'(e_ovf));
        end
    endtask

    int edge_vals[6] = '{0, 9, 10, 99, 100, 255};

    // ---------------- main sequence ----------------
    initial begin
        int lat, nb, ndone, d1, d2;
        logic [4*DIGITS-1:0] r1, r2;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset seg", 64'(seg_out), 64'({7'h7E, 7'h7E}));
        reset = 1'b0;

        // Latency and busy length.
        run_conv(8'd42, lat, nb);
        chk("latency 42", 64'(lat), 64'(10));
        chk("busy cycles 42", 64'(nb), 64'(8));
        chk("lit 42 bcd", 64'(bcd_out), 64'(8'h42));
        chk("lit 42 seg", 64'(seg_out), 64'({7'h33, 7'h6D}));
        chk("lit 42 ovf", 64'(overflow), 64'(0));

        directed("lit 99", 8'd99, 8'h99, {7'h7B, 7'h7B}, 1'b0);
        directed("lit 100", 8'd100, 8'h00, {7'h01, 7'h01}, 1'b1);
        directed("lit 255", 8'd255, 8'h55, {7'h01, 7'h01}, 1'b1);
`ifdef LCD_INT_BLANK_EN
        directed("lit 7", 8'd7, 8'h07, {7'h00, 7'h70}, 1'b0);
        directed("lit 0", 8'd0, 8'h00, {7'h00, 7'h7E}, 1'b0);
`else
        directed("lit 7", 8'd7, 8'h07, {7'h7E, 7'h70}, 1'b0);
        directed("lit 0", 8'd0, 8'h00, {7'h7E, 7'h7E}, 1'b0);
`endif
        directed("lit 10", 8'd10, 8'h10, {7'h30, 7'h7E}, 1'b0);

        // start while busy is ignored.
        @(negedge clk);
        start = 1'b1; bin_in = 8'd42;
        ndone = 0; r1 = '0;
        for (int i = 1; i <= 2 * W + 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) begin start = 1'b1; bin_in = 8'd13; end
            if (i == 4) start = 1'b0;
            if (done) begin ndone++; r1 = bcd_out; end
        end
        chk("busy-start done count", 64'(ndone), 64'(1));
        chk("busy-start result", 64'(r1), 64'(8'h42));

        // start held high: back-to-back conversions.
        @(negedge clk);
        start = 1'b1; bin_in = 8'd42;
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int i = 1; i <= 3 * W + 6; i++) begin
            @(negedge clk);
            if (i == 1) bin_in = 8'd77;
            if (i == W + 2) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin d1 = i; r1 = bcd_out; end
                else if (d2 < 0) begin d2 = i; r2 = bcd_out; end
            end
        end
        if (d2 < 0) fail_timeout("back-to-back");
        else begin
            chk("b2b first result", 64'(r1), 64'(8'h42));
            chk("b2b second result", 64'(r2), 64'(8'h77));
            chk("b2b spacing", 64'(d2 - d1), 64'(9));
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1; bin_in = 8'd42;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid-reset busy", 64'(busy), 64'(0));
        chk("mid-reset done", 64'(done), 64'(0));
        chk("mid-reset bcd", 64'(bcd_out), 64'(0));
        chk("mid-reset seg", 64'(seg_out), 64'({7'h7E, 7'h7E}));
        ndone = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid-reset no done", 64'(ndone), 64'(0));
        directed("after reset 58", 8'd58, 8'h58, {7'h5B, 7'h7F}, 1'b0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) bin_in = W'(edge_vals[$urandom_range(0, 5)]);
            else bin_in = W'($urandom_range(0, 255));
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2 * W + 4) @(negedge clk);

        // Wide instance: W=10, DIGITS=4.
        @(negedge clk);
        start2 = 1'b1; bin2 = 10'd1023;
        lat = -1;
        for (int i = 1; i <= 4 * W2 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 1) start2 = 1'b0;
            if (done2) lat = i;
        end
        if (lat < 0) fail_timeout("wide 1023");
        else begin
            chk("wide latency", 64'(lat), 64'(12));
            chk("wide bcd", 64'(bcd2), 64'(16'h1023));
            chk("wide ovf", 64'(ovf2), 64'(0));
            chk("wide seg", 64'(seg2), 64'({7'h30, 7'h7E, 7'h6D, 7'h79}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
